// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access at a time, bridged onto a simple req/ack bus with byte lanes.
// Optional MISALIGN_CHECK_EN: misaligned halfword/word accesses answer with err and no bus cycle.

`ifndef MEM_MODE_WORD
`define MEM_MODE_WORD       3'd0
`endif
`ifndef MEM_MODE_BYTE
`define MEM_MODE_BYTE       3'd1
`endif
`ifndef MEM_MODE_BYTE_SIGN
`define MEM_MODE_BYTE_SIGN  3'd2
`endif
`ifndef MEM_MODE_HWORD
`define MEM_MODE_HWORD      3'd3
`endif
`ifndef MEM_MODE_HWORD_SIGN
`define MEM_MODE_HWORD_SIGN 3'd4
`endif

module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_acc_mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [2:0]    mode_q, mode_d;
  logic [1:0]    lane_q, lane_d;
  logic          load_q, load_d;
  logic          ready_q, ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [DW-1:0] bus_addr_q, bus_addr_d;
  logic [BW-1:0] bus_be_q, bus_be_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;

  logic [2:0]    req_mode_c;
  logic [BW-1:0] req_be_c;
  logic [DW-1:0] req_wdata_c;
  logic          misalign_c;
  logic [7:0]    ld_byte_c;
  logic [15:0]   ld_half_c;
  logic [DW-1:0] ld_data_c;

  // Decode the incoming request: normalised mode, lane enables, lane-replicated store data.
  always_comb begin
    req_mode_c  = `MEM_MODE_WORD;
    req_be_c    = 4'b1111;
    req_wdata_c = wdata;
    case (mem_acc_mode)
      `MEM_MODE_BYTE, `MEM_MODE_BYTE_SIGN: begin
        req_mode_c  = mem_acc_mode;
        req_be_c    = 4'b0001 << addr[1:0];
        req_wdata_c = {4{wdata[7:0]}};
      end
      `MEM_MODE_HWORD, `MEM_MODE_HWORD_SIGN: begin
        req_mode_c  = mem_acc_mode;
        req_be_c    = addr[1] ? 4'b1100 : 4'b0011;
        req_wdata_c = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_CHECK_EN
  always_comb begin
    case (mem_acc_mode)
      `MEM_MODE_BYTE, `MEM_MODE_BYTE_SIGN:   misalign_c = 1'b0;
      `MEM_MODE_HWORD, `MEM_MODE_HWORD_SIGN: misalign_c = addr[0];
      default:                               misalign_c = |addr[1:0];
    endcase
  end
`else
  assign misalign_c = 1'b0;
`endif

  // Pick the addressed lane(s) out of the bus read data and extend per mode.
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte_c = bus_rdata[7:0];
      2'd1:    ld_byte_c = bus_rdata[15:8];
      2'd2:    ld_byte_c = bus_rdata[23:16];
      default: ld_byte_c = bus_rdata[31:24];
    endcase
    ld_half_c = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (mode_q)
      `MEM_MODE_BYTE:       ld_data_c = {24'h0, ld_byte_c};
      `MEM_MODE_BYTE_SIGN:  ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      `MEM_MODE_HWORD:      ld_data_c = {16'h0, ld_half_c};
      `MEM_MODE_HWORD_SIGN: ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
      default:              ld_data_c = bus_rdata;
    endcase
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    lane_d       = lane_q;
    load_d       = load_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    err_d        = 1'b0;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid && (mem_read || mem_write)) begin
          mode_d = req_mode_c;
          lane_d = addr[1:0];
          load_d = !mem_write;
          if (misalign_c) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
            rdata_d      = '0;
          end else begin
            state_d     = BUS;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_be_d    = req_be_c;
            bus_wdata_d = mem_write ? req_wdata_c : '0;
          end
        end
      end
      BUS: begin
        if (bus_ack) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          rdata_d      = load_q ? ld_data_c : '0;
          bus_req_d    = 1'b0;
          bus_we_d     = 1'b0;
          bus_addr_d   = '0;
          bus_be_d     = '0;
          bus_wdata_d  = '0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= `MEM_MODE_WORD;
      lane_q       <= 2'd0;
      load_q       <= 1'b0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_be_q     <= '0;
      bus_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      lane_q       <= lane_d;
      load_q       <= load_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign rdata      = rdata_q;
  assign err        = err_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;

endmodule
